// File: rtl/frame_buffer_matrix3_sequencer_if.sv
// Pixel stream handshake plus buffer write/read bus and kernel-side matrix tags.
// master drives the pixel stream; slave is the sequencer.
interface frame_buffer_matrix3_sequencer_if #(
  parameter int P_COLUMNS     = 640,
  parameter int P_LINES       = 480,
  parameter int P_PIXEL_DEPTH = 8
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int LW = $clog2(P_LINES);

  logic [P_PIXEL_DEPTH-1:0] I_PIXEL;
  logic                     I_PIXEL_VALID;
  logic                     O_PIXEL_READY;
  logic [CW-1:0]            O_COLUMN;
  logic [1:0]               O_ROW;
  logic [P_PIXEL_DEPTH-1:0] O_PIXEL;
  logic                     O_WRITE_ENABLE;
  logic                     O_READ_ENABLE;
  logic                     O_MATRIX_VALID;
  logic [CW-1:0]            O_CENTER_COLUMN;
  logic [LW-1:0]            O_CENTER_LINE;
  logic                     O_FRAME_DONE;

  modport master (
    output I_PIXEL, I_PIXEL_VALID,
    input  O_PIXEL_READY, O_COLUMN, O_ROW, O_PIXEL, O_WRITE_ENABLE, O_READ_ENABLE,
           O_MATRIX_VALID, O_CENTER_COLUMN, O_CENTER_LINE, O_FRAME_DONE
  );

  modport slave (
    input  I_PIXEL, I_PIXEL_VALID,
    output O_PIXEL_READY, O_COLUMN, O_ROW, O_PIXEL, O_WRITE_ENABLE, O_READ_ENABLE,
           O_MATRIX_VALID, O_CENTER_COLUMN, O_CENTER_LINE, O_FRAME_DONE
  );
endinterface

// File: rtl/frame_buffer_matrix3_sequencer.sv
// Write/read sequencer for a 3-row rolling frame buffer: writes raster pixels into
// row (line mod 3), then sweeps the centre line once its neighbours are resident.
module frame_buffer_matrix3_sequencer #(
  parameter int P_COLUMNS      = 640,
  parameter int P_LINES        = 480,
  parameter int P_PIXEL_DEPTH  = 8,
  parameter int P_READ_LATENCY = 1
) (
  input logic I_CLK,
  input logic I_RESET,
  frame_buffer_matrix3_sequencer_if.slave bus
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int LW = $clog2(P_LINES);
  localparam logic [CW-1:0] COL_LAST      = CW'(P_COLUMNS - 1);
  localparam logic [LW-1:0] LINE_LAST     = LW'(P_LINES - 1);
  localparam logic [LW-1:0] LINE_CTR_LAST = LW'(P_LINES - 2);

  typedef enum logic [1:0] {S_WRITE, S_READ, S_DRAIN} state_t;
  typedef struct packed {
    logic          vld;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
  } tag_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d, rd_col_q, rd_col_d, ocol_q, ocol_d;
  logic [LW-1:0]            line_q, line_d, ctr_line_q, ctr_line_d, oline_q, oline_d;
  logic [1:0]               wr_row_q, wr_row_d, rd_row_q, rd_row_d, orow_q, orow_d;
  logic [1:0]               drain_q, drain_d;
  logic [P_PIXEL_DEPTH-1:0] opix_q, opix_d;
  logic                     we_q, we_d, re_q, re_d;
  logic                     ready, accept;
  tag_t                     tag_in, tag_out;
  logic [CW-1:0]            hcol_q;
  logic [LW-1:0]            hline_q;

  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign ready  = (state_q == S_WRITE) && !I_RESET;
  assign accept = ready && bus.I_PIXEL_VALID;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    wr_row_d   = wr_row_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    ctr_line_d = ctr_line_q;
    drain_d    = drain_q;
    ocol_d     = ocol_q;
    orow_d     = orow_q;
    oline_d    = oline_q;
    opix_d     = opix_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    case (state_q)
      S_WRITE: begin
        if (accept) begin
          we_d   = 1'b1;
          ocol_d = col_q;
          orow_d = wr_row_q;
          opix_d = bus.I_PIXEL;
          if (col_q == COL_LAST) begin
            col_d    = '0;
            wr_row_d = (wr_row_q == 2'd2) ? 2'd0 : wr_row_q + 2'd1;
            line_d   = line_q + LW'(1);
            // Frame end: the row rotation restarts at 0 regardless of P_LINES mod 3.
            if (line_q == LINE_LAST) begin
              line_d   = '0;
              wr_row_d = 2'd0;
            end
            if (line_q >= LW'(2)) begin
              state_d    = S_READ;
              rd_row_d   = (wr_row_q == 2'd0) ? 2'd2 : wr_row_q - 2'd1;
              rd_col_d   = '0;
              ctr_line_d = line_q - LW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_READ: begin
        re_d    = 1'b1;
        ocol_d  = rd_col_q;
        orow_d  = rd_row_q;
        oline_d = ctr_line_q;
        if (rd_col_q == COL_LAST) begin
          rd_col_d = '0;
          if (P_READ_LATENCY == 0) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_DRAIN;
            drain_d = 2'(P_READ_LATENCY - 1);
          end
        end else begin
          rd_col_d = rd_col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_WRITE;
        else                 drain_d = drain_q - 2'd1;
      end
      default: state_d = S_WRITE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q    <= S_WRITE;
      col_q      <= '0;
      line_q     <= '0;
      wr_row_q   <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      ctr_line_q <= '0;
      drain_q    <= '0;
      ocol_q     <= '0;
      orow_q     <= '0;
      oline_q    <= '0;
      opix_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      wr_row_q   <= wr_row_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      ctr_line_q <= ctr_line_d;
      drain_q    <= drain_d;
      ocol_q     <= ocol_d;
      orow_q     <= orow_d;
      oline_q    <= oline_d;
      opix_q     <= opix_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  // Read tags travel with the buffer's read latency so they line up with its matrix.
  assign tag_in = '{vld: re_q, col: ocol_q, line: oline_q};

  generate
    if (P_READ_LATENCY == 0) begin : g_lat0
      assign tag_out = tag_in;
    end else begin : g_latn
      tag_t tag_pipe_q [P_READ_LATENCY];
      always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
          for (int i = 0; i < P_READ_LATENCY; i++) tag_pipe_q[i] <= '0;
        end else begin
          tag_pipe_q[0] <= tag_in;
          for (int i = 1; i < P_READ_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
        end
      end
      assign tag_out = tag_pipe_q[P_READ_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      hcol_q  <= '0;
      hline_q <= '0;
    end else if (tag_out.vld) begin
      hcol_q  <= tag_out.col;
      hline_q <= tag_out.line;
    end
  end

  assign bus.O_PIXEL_READY   = ready;
  assign bus.O_COLUMN        = ocol_q;
  assign bus.O_ROW           = orow_q;
  assign bus.O_PIXEL         = opix_q;
  assign bus.O_WRITE_ENABLE  = we_q;
  assign bus.O_READ_ENABLE   = re_q;
  assign bus.O_MATRIX_VALID  = tag_out.vld;
  assign bus.O_CENTER_COLUMN = tag_out.vld ? tag_out.col  : hcol_q;
  assign bus.O_CENTER_LINE   = tag_out.vld ? tag_out.line : hline_q;
  assign bus.O_FRAME_DONE    = tag_out.vld && (tag_out.col == COL_LAST) &&
                               (tag_out.line == LINE_CTR_LAST);
endmodule

// File: tb/tb_frame_buffer_matrix3_sequencer.sv
// Directed 4x4 table checks and reset corners, plus randomized multi-config runs
// against an arithmetic raster model of expected writes and matrix centres.
module tb_frame_buffer_matrix3_sequencer;
  localparam int CFG_C   [3] = '{3, 5, 16};
  localparam int CFG_L   [3] = '{5, 4, 6};
  localparam int CFG_LAT [3] = '{0, 3, 1};
  localparam int FRAMES      = 3;

  typedef struct { int col; int row; int pix; } wr_t;
  typedef struct { int col; int line; bit done; } mx_t;
  typedef struct { int pix; int col; int row; } dvec_t;

  bit clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit go = 0;
  bit gdone [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic rst0;
  frame_buffer_matrix3_sequencer_if #(.P_COLUMNS(4), .P_LINES(4), .P_PIXEL_DEPTH(8)) bus0();
  frame_buffer_matrix3_sequencer #(.P_COLUMNS(4), .P_LINES(4), .P_PIXEL_DEPTH(8),
    .P_READ_LATENCY(1)) u0 (.I_CLK(clk), .I_RESET(rst0), .bus(bus0));

  wr_t qw0[$];
  mx_t qm0[$];
  int  qrun0[$];
  int  run0 = 0;

  always @(negedge clk) begin
    if (bus0.O_WRITE_ENABLE)
      qw0.push_back('{int'(bus0.O_COLUMN), int'(bus0.O_ROW), int'(bus0.O_PIXEL)});
    if (bus0.O_MATRIX_VALID)
      qm0.push_back('{int'(bus0.O_CENTER_COLUMN), int'(bus0.O_CENTER_LINE), bus0.O_FRAME_DONE});
    if (!bus0.O_PIXEL_READY) run0++;
    else if (run0 > 0) begin qrun0.push_back(run0); run0 = 0; end
  end

  task automatic send0(input int pix);
    int t = 0;
    bus0.I_PIXEL = 8'(pix);
    bus0.I_PIXEL_VALID = 1'b1;
    while (!bus0.O_PIXEL_READY && t < 100) begin @(negedge clk); t++; end
    chk("send_ready_timeout", int'(t < 100), 1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, int'(bus0.O_PIXEL_READY), 0);
    chk({tag, "_we"},    int'(bus0.O_WRITE_ENABLE), 0);
    chk({tag, "_re"},    int'(bus0.O_READ_ENABLE), 0);
    chk({tag, "_mv"},    int'(bus0.O_MATRIX_VALID), 0);
    chk({tag, "_done"},  int'(bus0.O_FRAME_DONE), 0);
    chk({tag, "_col"},   int'(bus0.O_COLUMN), 0);
    chk({tag, "_row"},   int'(bus0.O_ROW), 0);
    chk({tag, "_pix"},   int'(bus0.O_PIXEL), 0);
    chk({tag, "_ccol"},  int'(bus0.O_CENTER_COLUMN), 0);
    chk({tag, "_cline"}, int'(bus0.O_CENTER_LINE), 0);
  endtask

  initial begin
    dvec_t dv [16];
    mx_t   dm [8];
    int    rows [16] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 0,0,0,0};
    int    t;
    for (int n = 0; n < 16; n++) dv[n] = '{16 + n, n % 4, rows[n]};
    for (int n = 0; n < 8; n++)  dm[n] = '{n % 4, 1 + n / 4, bit'(n == 7)};

    rst0 = 1'b1;
    bus0.I_PIXEL_VALID = 1'b0;
    bus0.I_PIXEL = '0;
    @(negedge clk);
    chk_zero("reset");
    rst0 = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus0.O_PIXEL_READY), 1);
    qw0.delete(); qm0.delete(); qrun0.delete();

    for (int n = 0; n < 16; n++) send0(dv[n].pix);
    bus0.I_PIXEL_VALID = 1'b0;
    repeat (20) @(negedge clk);
    chk("dir_wr_count", qw0.size(), 16);
    for (int n = 0; n < 16 && n < qw0.size(); n++) begin
      chk("dir_wr_col", qw0[n].col, dv[n].col);
      chk("dir_wr_row", qw0[n].row, dv[n].row);
      chk("dir_wr_pix", qw0[n].pix, dv[n].pix);
    end
    chk("dir_mx_count", qm0.size(), 8);
    for (int n = 0; n < 8 && n < qm0.size(); n++) begin
      chk("dir_mx_col",  qm0[n].col,  dm[n].col);
      chk("dir_mx_line", qm0[n].line, dm[n].line);
      chk("dir_mx_done", int'(qm0[n].done), int'(dm[n].done));
    end
    chk("dir_ready_gaps", qrun0.size(), 2);
    foreach (qrun0[i]) chk("dir_ready_gap_len", qrun0[i], 5);

    // Reset in the middle of a sweep, asserted between clock edges.
    for (int n = 0; n < 12; n++) send0(n);
    bus0.I_PIXEL_VALID = 1'b0;
    t = 0;
    while (!(bus0.O_READ_ENABLE && bus0.O_COLUMN == 2'd2) && t < 100) begin
      @(negedge clk); t++;
    end
    chk("sweep_reached_col2", int'(t < 100), 1);
    #2 rst0 = 1'b1;
    #1 chk_zero("midsweep_reset");
    @(negedge clk);
    rst0 = 1'b0;
    qw0.delete(); qm0.delete(); qrun0.delete();
    @(negedge clk);
    chk("ready_after_midsweep", int'(bus0.O_PIXEL_READY), 1);
    send0(8'hAA);
    bus0.I_PIXEL_VALID = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_wr_count", qw0.size(), 1);
    if (qw0.size() > 0) begin
      chk("post_reset_wr_col", qw0[0].col, 0);
      chk("post_reset_wr_row", qw0[0].row, 0);
      chk("post_reset_wr_pix", qw0[0].pix, 8'hAA);
    end
    chk("post_reset_no_matrix", qm0.size(), 0);

    go = 1'b1;
    t = 0;
    while (!(gdone[0] && gdone[1] && gdone[2]) && t < 50000) begin @(negedge clk); t++; end
    chk("random_phase_finished", int'(t < 50000), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int C   = CFG_C[g];
    localparam int L   = CFG_L[g];
    localparam int LAT = CFG_LAT[g];
    localparam int N   = C * L * FRAMES;

    logic rst;
    frame_buffer_matrix3_sequencer_if #(.P_COLUMNS(C), .P_LINES(L), .P_PIXEL_DEPTH(8)) bus();
    frame_buffer_matrix3_sequencer #(.P_COLUMNS(C), .P_LINES(L), .P_PIXEL_DEPTH(8),
      .P_READ_LATENCY(LAT)) dut (.I_CLK(clk), .I_RESET(rst), .bus(bus));

    initial begin
      wr_t ew[$];
      mx_t em[$];
      wr_t e;
      mx_t m;
      bit  hist [4];
      int  k, run, cyc, tail, lc, ll, v, p, col, line;
      k = 0; run = 0; cyc = 0; tail = 0; lc = 0; ll = 0; p = 0;
      foreach (hist[i]) hist[i] = 1'b0;
      gdone[g] = 1'b0;
      rst = 1'b1;
      bus.I_PIXEL_VALID = 1'b0;
      bus.I_PIXEL = '0;
      wait (go);
      @(negedge clk);
      rst = 1'b0;
      while ((k < N || tail < 40) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        chk("we_re_exclusive", int'(bus.O_WRITE_ENABLE && bus.O_READ_ENABLE), 0);
        if (bus.O_WRITE_ENABLE) begin
          if (ew.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            e = ew.pop_front();
            chk("rnd_wr_col", int'(bus.O_COLUMN), e.col);
            chk("rnd_wr_row", int'(bus.O_ROW), e.row);
            chk("rnd_wr_pix", int'(bus.O_PIXEL), e.pix);
            // Only the line-completing write may still have its sweep outstanding.
            chk("write_during_sweep", int'(em.size() > 0 && e.col != C - 1), 0);
          end
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.O_READ_ENABLE;
        chk("valid_lag", int'(bus.O_MATRIX_VALID), int'(hist[LAT]));
        if (bus.O_MATRIX_VALID) begin
          if (em.size() == 0) chk("unexpected_matrix", 1, 0);
          else begin
            m = em.pop_front();
            chk("rnd_mx_col",  int'(bus.O_CENTER_COLUMN), m.col);
            chk("rnd_mx_line", int'(bus.O_CENTER_LINE), m.line);
            chk("rnd_mx_done", int'(bus.O_FRAME_DONE), int'(m.done));
            lc = m.col; ll = m.line;
          end
        end else begin
          chk("hold_col",  int'(bus.O_CENTER_COLUMN), lc);
          chk("hold_line", int'(bus.O_CENTER_LINE), ll);
          chk("done_idle", int'(bus.O_FRAME_DONE), 0);
        end
        if (!bus.O_PIXEL_READY) run++;
        else begin
          if (run > 0) chk("ready_low_len", run, C + LAT);
          run = 0;
        end

        if (k < N) begin
          v = $urandom_range(0, 1);
          p = $urandom_range(0, 255);
        end else begin
          v = 0;
          tail++;
        end
        bus.I_PIXEL_VALID = v[0];
        bus.I_PIXEL = 8'(p);
        if (v != 0 && bus.O_PIXEL_READY) begin
          col  = k % C;
          line = (k / C) % L;
          ew.push_back('{col, line % 3, p});
          if (col == C - 1 && line >= 2)
            for (int c = 0; c < C; c++)
              em.push_back('{c, line - 1, bit'(line == L - 1 && c == C - 1)});
          k++;
        end
      end
      chk("rnd_cycle_budget", int'(cyc < 20000), 1);
      chk("rnd_writes_drained", ew.size(), 0);
      chk("rnd_matrices_drained", em.size(), 0);
      gdone[g] = 1'b1;
    end
  end
endmodule
